// File: rtl/multicycle_ctrl_pkg.sv
// mc_pkg: shared definitions for the multicycle MIPS32 control unit.
// Contents: FSM state enum (4-bit, FETCH = 0), opcode and funct constants,
// ALU control codes, alu_src_b / pc_source select encodings, and a helper
// that identifies the states that own the shared memory port.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_I_EXEC    = 4'd10,
        S_I_WB      = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // States that hold the memory port and therefore wait on mem_ready.
    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: bundle between the control unit and the datapath.
// Datapath -> control: opcode, funct (IR fields), zero (ALU flag), mem_ready.
// Control -> datapath: every mux select, write enable and memory strobe,
// plus the instr_done / illegal pulses and the sticky mem_timeout flag.
// master = control unit side, slave = datapath / memory side.
interface multicycle_ctrl_if;
    import mc_pkg::*;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    logic       pc_write;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_control;
    logic       instr_done;
    logic       illegal;
    logic       mem_timeout;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output pc_write, pc_source, iord, mem_read, mem_write, ir_write,
               reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
               alu_control, instr_done, illegal, mem_timeout
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  pc_write, pc_source, iord, mem_read, mem_write, ir_write,
               reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
               alu_control, instr_done, illegal, mem_timeout
    );

endinterface

// File: rtl/multicycle_ctrl_alu_decode.sv
// alu_decode: maps an R-type funct field to an ALU operation.
// Ports: funct (in, 6) latched funct; alu_control (out, 4) ALU operation;
// valid (out, 1) high when funct is one of add/sub/and/or/slt.
module alu_decode
    import mc_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_control,
    output logic       valid
);

    always_comb begin
        alu_control = ALU_ADD;
        valid       = 1'b1;
        case (funct)
            FN_ADD:  alu_control = ALU_ADD;
            FN_SUB:  alu_control = ALU_SUB;
            FN_AND:  alu_control = ALU_AND;
            FN_OR:   alu_control = ALU_OR;
            FN_SLT:  alu_control = ALU_SLT;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle control FSM for the MIPS32 core.
// Ports: clock, reset (async, active-high); bus (multicycle_ctrl_if.master)
// carrying the IR fields, ALU zero flag and mem_ready in, and all datapath
// selects/enables, instr_done, illegal and the sticky mem_timeout out.
// WAIT_LIMIT: consecutive mem_ready-low cycles before mem_timeout is raised.
module multicycle_ctrl
    import mc_pkg::*;
#(
    parameter int WAIT_LIMIT = 255
)(
    input  logic                 clock,
    input  logic                 reset,
    multicycle_ctrl_if.master    bus
);

    localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

    state_t     state;
    state_t     next_state;
    logic [5:0] op_q;
    logic [5:0] funct_q;
    logic [7:0] wait_cnt;
    logic       timeout_q;
    logic       waiting;
    logic [3:0] r_alu;
    logic       r_valid;

    alu_decode u_alu_decode (
        .funct       (funct_q),
        .alu_control (r_alu),
        .valid       (r_valid)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= next_state;
    end

    // The IR may change after DECODE, so later states use these copies.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_q    <= '0;
            funct_q <= '0;
        end else if (state == S_DECODE) begin
            op_q    <= bus.opcode;
            funct_q <= bus.funct;
        end
    end

    // Counter saturates at LIMIT so the sticky flag cannot be lost by wrap.
    assign waiting = is_mem_state(state) && !bus.mem_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else if (!waiting) begin
            wait_cnt <= '0;
        end else if (wait_cnt != LIMIT) begin
            wait_cnt <= wait_cnt + 8'd1;
            if (wait_cnt + 8'd1 == LIMIT) timeout_q <= 1'b1;
        end
    end

    assign bus.mem_timeout = timeout_q;

    // Outputs are gated by reset combinationally so strobes drop without
    // waiting for a clock edge.
    always_comb begin
        next_state      = state;
        bus.pc_write    = 1'b0;
        bus.pc_source   = PCSRC_ALU;
        bus.iord        = 1'b0;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.ir_write    = 1'b0;
        bus.reg_write   = 1'b0;
        bus.reg_dst     = 1'b0;
        bus.mem_to_reg  = 1'b0;
        bus.alu_src_a   = 1'b0;
        bus.alu_src_b   = SRCB_REG;
        bus.alu_control = ALU_ADD;
        bus.instr_done  = 1'b0;
        bus.illegal     = 1'b0;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    bus.mem_read  = 1'b1;
                    bus.alu_src_b = SRCB_FOUR;
                    if (bus.mem_ready) begin
                        bus.ir_write = 1'b1;
                        bus.pc_write = 1'b1;
                        next_state   = S_DECODE;
                    end
                end
                S_DECODE: begin
                    bus.alu_src_b = SRCB_IMM_SH2;
                    case (bus.opcode)
                        OP_LW, OP_SW:   next_state = S_MEM_ADDR;
                        OP_RTYPE:       next_state = S_R_EXEC;
                        OP_BEQ, OP_BNE: next_state = S_BRANCH;
                        OP_ADDI:        next_state = S_I_EXEC;
                        OP_J:           next_state = S_JUMP;
                        default: begin
                            bus.illegal = 1'b1;
                            next_state  = S_FETCH;
                        end
                    endcase
                end
                S_MEM_ADDR: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = SRCB_IMM;
                    next_state    = (op_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
                end
                S_MEM_READ: begin
                    bus.mem_read = 1'b1;
                    bus.iord     = 1'b1;
                    if (bus.mem_ready) next_state = S_MEM_WB;
                end
                S_MEM_WB: begin
                    bus.reg_write  = 1'b1;
                    bus.mem_to_reg = 1'b1;
                    bus.instr_done = 1'b1;
                    next_state     = S_FETCH;
                end
                S_MEM_WRITE: begin
                    bus.mem_write = 1'b1;
                    bus.iord      = 1'b1;
                    if (bus.mem_ready) begin
                        bus.instr_done = 1'b1;
                        next_state     = S_FETCH;
                    end
                end
                S_R_EXEC: begin
                    bus.alu_src_a   = 1'b1;
                    bus.alu_control = r_alu;
                    if (r_valid) begin
                        next_state = S_R_WB;
                    end else begin
                        bus.illegal = 1'b1;
                        next_state  = S_FETCH;
                    end
                end
                S_R_WB: begin
                    bus.reg_write   = 1'b1;
                    bus.reg_dst     = 1'b1;
                    bus.alu_control = r_alu;
                    bus.instr_done  = 1'b1;
                    next_state      = S_FETCH;
                end
                S_BRANCH: begin
                    bus.alu_src_a   = 1'b1;
                    bus.alu_control = ALU_SUB;
                    bus.pc_source   = PCSRC_ALUOUT;
                    bus.pc_write    = ((op_q == OP_BEQ) &&  bus.zero) ||
                                      ((op_q == OP_BNE) && !bus.zero);
                    bus.instr_done  = 1'b1;
                    next_state      = S_FETCH;
                end
                S_JUMP: begin
                    bus.pc_source  = PCSRC_JUMP;
                    bus.pc_write   = 1'b1;
                    bus.instr_done = 1'b1;
                    next_state     = S_FETCH;
                end
                S_I_EXEC: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = SRCB_IMM;
                    next_state    = S_I_WB;
                end
                S_I_WB: begin
                    bus.reg_write  = 1'b1;
                    bus.instr_done = 1'b1;
                    next_state     = S_FETCH;
                end
                default: next_state = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: self-checking bench for multicycle_ctrl (WAIT_LIMIT = 4).
// The reference model expands each instruction into a per-cycle list of
// expected control outputs (with a care mask for selects the design leaves
// unspecified) and the stimulus to apply in that cycle.
module tb_multicycle_ctrl;

    localparam logic [5:0] OPC_R    = 6'b000000;
    localparam logic [5:0] OPC_LW   = 6'b100011;
    localparam logic [5:0] OPC_SW   = 6'b101011;
    localparam logic [5:0] OPC_BEQ  = 6'b000100;
    localparam logic [5:0] OPC_BNE  = 6'b000101;
    localparam logic [5:0] OPC_ADDI = 6'b001000;
    localparam logic [5:0] OPC_J    = 6'b000010;

    typedef struct packed {
        logic       pc_write;
        logic [1:0] pc_source;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_control;
        logic       instr_done;
        logic       illegal;
        logic       mem_timeout;
    } ctrl_t;

    typedef struct {
        ctrl_t      exp;
        ctrl_t      care;
        logic       ready;
        logic       zero;
        logic [5:0] op;
        logic [5:0] fn;
    } step_t;

    logic  clock = 1'b0;
    logic  reset;
    int    errors = 0;
    int    checks = 0;
    step_t trace[$];

    multicycle_ctrl_if bus();

    multicycle_ctrl #(.WAIT_LIMIT(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    function automatic ctrl_t observe();
        ctrl_t o;
        o.pc_write    = bus.pc_write;
        o.pc_source   = bus.pc_source;
        o.iord        = bus.iord;
        o.mem_read    = bus.mem_read;
        o.mem_write   = bus.mem_write;
        o.ir_write    = bus.ir_write;
        o.reg_write   = bus.reg_write;
        o.reg_dst     = bus.reg_dst;
        o.mem_to_reg  = bus.mem_to_reg;
        o.alu_src_a   = bus.alu_src_a;
        o.alu_src_b   = bus.alu_src_b;
        o.alu_control = bus.alu_control;
        o.instr_done  = bus.instr_done;
        o.illegal     = bus.illegal;
        o.mem_timeout = bus.mem_timeout;
        return o;
    endfunction

    // {valid, alu code} for an R-type funct.
    function automatic logic [4:0] ref_alu(input logic [5:0] fn);
        case (fn)
            6'b100000: return 5'b1_0010;
            6'b100010: return 5'b1_0110;
            6'b100100: return 5'b1_0000;
            6'b100101: return 5'b1_0001;
            6'b101010: return 5'b1_0111;
            default:   return 5'b0_0000;
        endcase
    endfunction

    // Baseline cycle: all strobes/pulses low, add, ALU A = PC, no timeout.
    // After DECODE the IR fields are driven with junk to prove they are latched.
    function automatic step_t new_step(input logic post, input logic rdy,
                                       input logic [5:0] op, input logic [5:0] fn);
        step_t s;
        s.exp              = '0;
        s.care             = '0;
        s.exp.alu_control  = 4'b0010;
        s.care.pc_write    = 1'b1;
        s.care.mem_read    = 1'b1;
        s.care.mem_write   = 1'b1;
        s.care.ir_write    = 1'b1;
        s.care.reg_write   = 1'b1;
        s.care.alu_src_a   = 1'b1;
        s.care.alu_control = 4'hF;
        s.care.instr_done  = 1'b1;
        s.care.illegal     = 1'b1;
        s.care.mem_timeout = 1'b1;
        s.ready            = rdy;
        s.zero             = 1'($urandom_range(0, 1));
        s.op               = post ? 6'($urandom) : op;
        s.fn               = post ? 6'($urandom) : fn;
        return s;
    endfunction

    // kind: 0 = instruction fetch, 1 = data read, 2 = data write.
    function automatic void add_mem(input int kind, input int waits,
                                    input logic [5:0] op, input logic [5:0] fn);
        step_t s;
        for (int w = 0; w <= waits; w++) begin
            s = new_step(kind != 0, w == waits, op, fn);
            s.care.iord = 1'b1;
            if (kind == 0) begin
                s.exp.mem_read  = 1'b1;
                s.care.alu_src_b = 2'b11;
                s.exp.alu_src_b  = 2'b01;
                s.care.pc_source = 2'b11;
                s.exp.pc_source  = 2'b00;
                s.exp.ir_write   = (w == waits);
                s.exp.pc_write   = (w == waits);
            end else begin
                s.exp.iord       = 1'b1;
                s.exp.mem_read   = (kind == 1);
                s.exp.mem_write  = (kind == 2);
                s.exp.instr_done = (kind == 2) && (w == waits);
            end
            trace.push_back(s);
        end
    endfunction

    function automatic void add_wb(input logic dst, input logic m2r, input logic [3:0] alu);
        step_t s;
        s = new_step(1'b1, 1'($urandom_range(0, 1)), 6'h0, 6'h0);
        s.exp.reg_write   = 1'b1;
        s.care.reg_dst    = 1'b1;
        s.exp.reg_dst     = dst;
        s.care.mem_to_reg = 1'b1;
        s.exp.mem_to_reg  = m2r;
        s.exp.alu_control = alu;
        s.exp.instr_done  = 1'b1;
        trace.push_back(s);
    endfunction

    function automatic void build_trace(input logic [5:0] op, input logic [5:0] fn,
                                        input logic z, input int fw, input int mw);
        step_t      s;
        logic [4:0] r;
        trace.delete();
        add_mem(0, fw, op, fn);
        s = new_step(1'b0, 1'($urandom_range(0, 1)), op, fn);
        s.care.alu_src_b = 2'b11;
        s.exp.alu_src_b  = 2'b11;
        if (!(op inside {OPC_R, OPC_LW, OPC_SW, OPC_BEQ, OPC_BNE, OPC_ADDI, OPC_J})) begin
            s.exp.illegal = 1'b1;
            trace.push_back(s);
            return;
        end
        trace.push_back(s);
        s = new_step(1'b1, 1'($urandom_range(0, 1)), 6'h0, 6'h0);
        case (op)
            OPC_LW, OPC_SW: begin
                s.exp.alu_src_a  = 1'b1;
                s.care.alu_src_b = 2'b11;
                s.exp.alu_src_b  = 2'b10;
                trace.push_back(s);
                add_mem((op == OPC_LW) ? 1 : 2, mw, 6'h0, 6'h0);
                if (op == OPC_LW) add_wb(1'b0, 1'b1, 4'b0010);
            end
            OPC_R: begin
                r = ref_alu(fn);
                s.exp.alu_src_a    = 1'b1;
                s.care.alu_src_b   = 2'b11;
                s.exp.alu_src_b    = 2'b00;
                s.exp.alu_control  = r[3:0];
                s.care.alu_control = r[4] ? 4'hF : 4'h0;
                s.exp.illegal      = !r[4];
                trace.push_back(s);
                if (r[4]) add_wb(1'b1, 1'b0, r[3:0]);
            end
            OPC_BEQ, OPC_BNE: begin
                s.zero            = z;
                s.exp.alu_src_a   = 1'b1;
                s.care.alu_src_b  = 2'b11;
                s.exp.alu_src_b   = 2'b00;
                s.exp.alu_control = 4'b0110;
                s.care.pc_source  = 2'b11;
                s.exp.pc_source   = 2'b01;
                s.exp.pc_write    = (op == OPC_BEQ) ? z : !z;
                s.exp.instr_done  = 1'b1;
                trace.push_back(s);
            end
            OPC_J: begin
                s.care.pc_source = 2'b11;
                s.exp.pc_source  = 2'b10;
                s.exp.pc_write   = 1'b1;
                s.exp.instr_done = 1'b1;
                trace.push_back(s);
            end
            default: begin
                s.exp.alu_src_a  = 1'b1;
                s.care.alu_src_b = 2'b11;
                s.exp.alu_src_b  = 2'b10;
                trace.push_back(s);
                add_wb(1'b0, 1'b0, 4'b0010);
            end
        endcase
    endfunction

    // Apply one cycle of stimulus just after the rising edge, sample on the falling edge.
    task automatic drive_step(input step_t s, output ctrl_t obs);
        bus.opcode    = s.op;
        bus.funct     = s.fn;
        bus.mem_ready = s.ready;
        bus.zero      = s.zero;
        @(negedge clock);
        obs = observe();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        ctrl_t obs;
        step_t s;
        reset         = 1'b1;
        bus.opcode    = OPC_LW;
        bus.funct     = 6'h0;
        bus.zero      = 1'b1;
        bus.mem_ready = 1'b1;
        s = new_step(1'b0, 1'b1, OPC_LW, 6'h0);
        s.care.alu_src_a = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            obs = observe();
            checks++;
            if (((obs ^ s.exp) & s.care) !== '0) begin
                errors++;
                $display("[TB] FAIL reset cycle %0d: got %05h expected %05h mask %05h", i, obs, s.exp, s.care);
            end
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_lw();
        ctrl_t obs;
        build_trace(OPC_LW, 6'h0, 1'b0, 0, 0);
        foreach (trace[i]) begin
            drive_step(trace[i], obs);
            checks++;
            if (((obs ^ trace[i].exp) & trace[i].care) !== '0) begin
                errors++;
                $display("[TB] FAIL lw cycle %0d: got %05h expected %05h mask %05h", i, obs, trace[i].exp, trace[i].care);
            end
        end
    endtask

    task automatic test_sw_waits();
        ctrl_t obs;
        build_trace(OPC_SW, 6'h0, 1'b0, 0, 3);
        foreach (trace[i]) begin
            drive_step(trace[i], obs);
            checks++;
            if (((obs ^ trace[i].exp) & trace[i].care) !== '0) begin
                errors++;
                $display("[TB] FAIL sw_waits cycle %0d: got %05h expected %05h mask %05h", i, obs, trace[i].exp, trace[i].care);
            end
        end
    endtask

    task automatic test_branches();
        ctrl_t      obs;
        logic [5:0] ops[4] = '{OPC_BEQ, OPC_BNE, OPC_BNE, OPC_BEQ};
        logic       zs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 4; k++) begin
            build_trace(ops[k], 6'h0, zs[k], 0, 0);
            foreach (trace[i]) begin
                drive_step(trace[i], obs);
                checks++;
                if (((obs ^ trace[i].exp) & trace[i].care) !== '0) begin
                    errors++;
                    $display("[TB] FAIL branch %0d cycle %0d: got %05h expected %05h mask %05h", k, i, obs, trace[i].exp, trace[i].care);
                end
            end
        end
    endtask

    task automatic test_rtype();
        ctrl_t      obs;
        logic [5:0] fns[3] = '{6'b100010, 6'b000011, 6'b101010};
        for (int k = 0; k < 3; k++) begin
            build_trace(OPC_R, fns[k], 1'b0, 1, 0);
            foreach (trace[i]) begin
                drive_step(trace[i], obs);
                checks++;
                if (((obs ^ trace[i].exp) & trace[i].care) !== '0) begin
                    errors++;
                    $display("[TB] FAIL rtype funct %b cycle %0d: got %05h expected %05h mask %05h", fns[k], i, obs, trace[i].exp, trace[i].care);
                end
            end
        end
    endtask

    task automatic test_illegal();
        ctrl_t obs;
        build_trace(6'b111111, 6'h0, 1'b0, 0, 0);
        build_trace(6'b111111, 6'h0, 1'b0, 0, 0);
        foreach (trace[i]) begin
            drive_step(trace[i], obs);
            checks++;
            if (((obs ^ trace[i].exp) & trace[i].care) !== '0) begin
                errors++;
                $display("[TB] FAIL illegal_op cycle %0d: got %05h expected %05h mask %05h", i, obs, trace[i].exp, trace[i].care);
            end
        end
        // A following addi proves the FSM went back to FETCH.
        build_trace(OPC_ADDI, 6'h0, 1'b0, 0, 0);
        foreach (trace[i]) begin
            drive_step(trace[i], obs);
            checks++;
            if (((obs ^ trace[i].exp) & trace[i].care) !== '0) begin
                errors++;
                $display("[TB] FAIL after_illegal cycle %0d: got %05h expected %05h mask %05h", i, obs, trace[i].exp, trace[i].care);
            end
        end
    endtask

    task automatic test_random();
        ctrl_t      obs;
        logic [5:0] ops[8] = '{OPC_R, OPC_LW, OPC_SW, OPC_BEQ, OPC_BNE, OPC_ADDI, OPC_J, 6'b110001};
        logic [5:0] fns[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        logic [5:0] op;
        logic [5:0] fn;
        for (int n = 0; n < 40; n++) begin
            op = ops[$urandom_range(0, 7)];
            fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
            build_trace(op, fn, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
            foreach (trace[i]) begin
                drive_step(trace[i], obs);
                checks++;
                if (((obs ^ trace[i].exp) & trace[i].care) !== '0) begin
                    errors++;
                    $display("[TB] FAIL random instr %0d op %b fn %b cycle %0d: got %05h expected %05h mask %05h", n, op, fn, i, obs, trace[i].exp, trace[i].care);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        ctrl_t obs;
        build_trace(OPC_SW, 6'h0, 1'b0, 0, 3);
        for (int i = 0; i < 3; i++) begin
            drive_step(trace[i], obs);
            checks++;
            if (((obs ^ trace[i].exp) & trace[i].care) !== '0) begin
                errors++;
                $display("[TB] FAIL reset_mid lead cycle %0d: got %05h expected %05h mask %05h", i, obs, trace[i].exp, trace[i].care);
            end
        end
        bus.mem_ready = 1'b0;
        #2;
        checks++;
        if (bus.mem_write !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_mid in_write: mem_write got %b expected 1", bus.mem_write);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.mem_write, bus.mem_read, bus.reg_write, bus.pc_write, bus.ir_write, bus.alu_control} !== 9'b00000_0010) begin
            errors++;
            $display("[TB] FAIL reset_mid async: strobes+alu got %b expected 000000010",
                     {bus.mem_write, bus.mem_read, bus.reg_write, bus.pc_write, bus.ir_write, bus.alu_control});
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        build_trace(OPC_LW, 6'h0, 1'b0, 1, 0);
        foreach (trace[i]) begin
            drive_step(trace[i], obs);
            checks++;
            if (((obs ^ trace[i].exp) & trace[i].care) !== '0) begin
                errors++;
                $display("[TB] FAIL reset_mid after cycle %0d: got %05h expected %05h mask %05h", i, obs, trace[i].exp, trace[i].care);
            end
        end
    endtask

    task automatic test_timeout();
        logic exp_to;
        reset         = 1'b1;
        bus.mem_ready = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            exp_to = (k >= 5);
            checks++;
            if (bus.mem_timeout !== exp_to) begin
                errors++;
                $display("[TB] FAIL timeout cycle %0d: mem_timeout got %b expected %b", k, bus.mem_timeout, exp_to);
            end
            checks++;
            if ({bus.mem_read, bus.iord, bus.ir_write, bus.pc_write} !== 4'b1000) begin
                errors++;
                $display("[TB] FAIL timeout hold cycle %0d: rd/iord/irw/pcw got %b expected 1000",
                         k, {bus.mem_read, bus.iord, bus.ir_write, bus.pc_write});
            end
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.mem_timeout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout clear: mem_timeout got %b expected 0", bus.mem_timeout);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_waits();
        test_branches();
        test_rtype();
        test_illegal();
        test_random();
        test_reset_mid();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
